// File: rtl/stopwatch_cmd_ctrl_if.sv
// Button levels and counter status into the command sequencer, arbitrated command pulses and run state out.
// master drives the buttons/stopped flag (board side), slave is the sequencer.
interface stopwatch_cmd_ctrl_if;
  logic btn_ss;
  logic btn_min;
  logic btn_hour;
  logic stopped;
  logic start;
  logic stop;
  logic min_inc;
  logic hour_inc;
  logic clr_req;
  logic running;

  modport master (
    output btn_ss, btn_min, btn_hour, stopped,
    input  start, stop, min_inc, hour_inc, clr_req, running
  );

  modport slave (
    input  btn_ss, btn_min, btn_hour, stopped,
    output start, stop, min_inc, hour_inc, clr_req, running
  );
endinterface

// File: rtl/stopwatch_cmd_ctrl.sv
// Stopwatch command sequencer: button levels -> one-cycle start/stop/clr/inc pulses, 1 cycle after the edge.
// No backpressure: losing commands wait one deep in pend bits; STOPWATCH_AUTO_RPT_EN enables inc auto-repeat.
module stopwatch_cmd_ctrl #(
  parameter int HOLD_DLY = 50,
  parameter int RPT_PER  = 10,
  parameter int CLR_HOLD = 200,
  parameter int CNT_W    = 8
) (
  input  logic                clk_100Hz,
  input  logic                rst_n,
  stopwatch_cmd_ctrl_if.slave bus
);

  typedef enum logic [1:0] {SS_IDLE, SS_HELD, SS_WAITREL} ss_state_t;
  typedef enum logic [1:0] {I_IDLE, I_HOLD, I_RPT} inc_state_t;

  // pend/req/gnt bit order: higher index wins arbitration
  localparam int P_MIN = 0, P_HOUR = 1, P_START = 2, P_CLR = 3, P_STOP = 4;
  localparam logic [CNT_W-1:0] CLR_TERM = CNT_W'(CLR_HOLD - 1);
`ifdef STOPWATCH_AUTO_RPT_EN
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_DLY - 1);
  localparam logic [CNT_W-1:0] RPT_TERM  = CNT_W'(RPT_PER - 1);
`endif

  ss_state_t        ss_state, ss_nxt;
  logic [CNT_W-1:0] ss_cnt, ss_cnt_nxt;
  inc_state_t       inc_state [2];
  inc_state_t       inc_nxt   [2];
`ifdef STOPWATCH_AUTO_RPT_EN
  logic [CNT_W-1:0] inc_cnt     [2];
  logic [CNT_W-1:0] inc_cnt_nxt [2];
`endif

  logic       ss_prev, stopped_prev, stop_d2;
  logic [1:0] inc_btn, inc_prev, inc_press, inc_ev;
  logic       ss_press, ev_stop, ev_start, ev_clr, auto_stop, running_nxt;
  logic [4:0] pend, pend_nxt, req, gnt;

  assign inc_btn   = {bus.btn_hour, bus.btn_min};
  assign inc_press = inc_btn & ~inc_prev;
  assign ss_press  = bus.btn_ss & ~ss_prev;

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      ss_state <= SS_IDLE;
      ss_cnt   <= '0;
      for (int i = 0; i < 2; i++) begin
        inc_state[i] <= I_IDLE;
`ifdef STOPWATCH_AUTO_RPT_EN
        inc_cnt[i]   <= '0;
`endif
      end
    end else begin
      ss_state <= ss_nxt;
      ss_cnt   <= ss_cnt_nxt;
      for (int i = 0; i < 2; i++) begin
        inc_state[i] <= inc_nxt[i];
`ifdef STOPWATCH_AUTO_RPT_EN
        inc_cnt[i]   <= inc_cnt_nxt[i];
`endif
      end
    end
  end

  // A press while running is a stop and is not eligible for clear.
  always_comb begin
    ss_nxt     = ss_state;
    ss_cnt_nxt = ss_cnt;
    case (ss_state)
      SS_IDLE: if (ss_press) begin
        ss_nxt     = bus.running ? SS_WAITREL : SS_HELD;
        ss_cnt_nxt = '0;
      end
      SS_HELD: begin
        if (!bus.btn_ss) begin
          ss_nxt     = SS_IDLE;
          ss_cnt_nxt = '0;
        end else if (ss_cnt == CLR_TERM) begin
          ss_nxt = SS_WAITREL;
        end else begin
          ss_cnt_nxt = ss_cnt + 1'b1;
        end
      end
      SS_WAITREL: if (!bus.btn_ss) begin
        ss_nxt     = SS_IDLE;
        ss_cnt_nxt = '0;
      end
      default: ss_nxt = SS_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      inc_nxt[i] = inc_state[i];
      case (inc_state[i])
        I_IDLE: if (inc_press[i]) inc_nxt[i] = I_HOLD;
        I_HOLD: begin
          if (!inc_btn[i]) inc_nxt[i] = I_IDLE;
`ifdef STOPWATCH_AUTO_RPT_EN
          else if (inc_cnt[i] == HOLD_TERM) inc_nxt[i] = I_RPT;
`endif
        end
`ifdef STOPWATCH_AUTO_RPT_EN
        I_RPT: if (!inc_btn[i]) inc_nxt[i] = I_IDLE;
`endif
        default: inc_nxt[i] = I_IDLE;
      endcase
`ifdef STOPWATCH_AUTO_RPT_EN
      // restart on every state change and on each repeat; hold at all-ones otherwise
      inc_cnt_nxt[i] = inc_cnt[i];
      if (inc_nxt[i] != inc_state[i] || (inc_state[i] == I_RPT && inc_cnt[i] == RPT_TERM))
        inc_cnt_nxt[i] = '0;
      else if (inc_state[i] != I_IDLE && inc_cnt[i] != '1)
        inc_cnt_nxt[i] = inc_cnt[i] + 1'b1;
`endif
    end
  end

  always_comb begin
    ev_stop  = (ss_state == SS_IDLE) && ss_press && bus.running;
    ev_start = (ss_state == SS_HELD) && !bus.btn_ss;
    ev_clr   = (ss_state == SS_HELD) && bus.btn_ss && (ss_cnt == CLR_TERM);
    inc_ev   = '0;
    for (int i = 0; i < 2; i++) begin
      case (inc_state[i])
        I_IDLE:  inc_ev[i] = inc_press[i];
`ifdef STOPWATCH_AUTO_RPT_EN
        I_HOLD:  inc_ev[i] = inc_btn[i] && (inc_cnt[i] == HOLD_TERM);
        I_RPT:   inc_ev[i] = inc_btn[i] && (inc_cnt[i] == RPT_TERM);
`endif
        default: inc_ev[i] = 1'b0;
      endcase
    end
    inc_ev = inc_ev & {2{~bus.running}};
  end

  // A 'stopped' rise shortly after our own stop is the counter catching up, not a countdown expiry.
  always_comb begin
    auto_stop = bus.stopped && !stopped_prev && bus.running && !bus.stop && !stop_d2;

    req          = '0;
    req[P_STOP]  = (pend[P_STOP] | ev_stop) & ~auto_stop;
    req[P_CLR]   = pend[P_CLR] | ev_clr;
    req[P_START] = (pend[P_START] | ev_start) & ~bus.running;
    req[P_HOUR]  = pend[P_HOUR] | inc_ev[1];
    req[P_MIN]   = pend[P_MIN] | inc_ev[0];

    gnt = '0;
    if      (req[P_STOP])  gnt[P_STOP]  = 1'b1;
    else if (req[P_CLR])   gnt[P_CLR]   = 1'b1;
    else if (req[P_START]) gnt[P_START] = 1'b1;
    else if (req[P_HOUR])  gnt[P_HOUR]  = 1'b1;
    else if (req[P_MIN])   gnt[P_MIN]   = 1'b1;

    pend_nxt = req & ~gnt;
    if (gnt[P_STOP]) pend_nxt[P_START] = 1'b0;
    if (gnt[P_CLR])  pend_nxt = '0;

    running_nxt = bus.running;
    if (gnt[P_START]) running_nxt = 1'b1;
    else if (gnt[P_STOP] || gnt[P_CLR] || auto_stop) running_nxt = 1'b0;
  end

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      ss_prev      <= 1'b0;
      inc_prev     <= '0;
      stopped_prev <= 1'b0;
      stop_d2      <= 1'b0;
      pend         <= '0;
      bus.stop     <= 1'b0;
      bus.clr_req  <= 1'b0;
      bus.start    <= 1'b0;
      bus.hour_inc <= 1'b0;
      bus.min_inc  <= 1'b0;
      bus.running  <= 1'b0;
    end else begin
      ss_prev      <= bus.btn_ss;
      inc_prev     <= inc_btn;
      stopped_prev <= bus.stopped;
      stop_d2      <= bus.stop;
      pend         <= pend_nxt;
      bus.stop     <= gnt[P_STOP];
      bus.clr_req  <= gnt[P_CLR];
      bus.start    <= gnt[P_START];
      bus.hour_inc <= gnt[P_HOUR];
      bus.min_inc  <= gnt[P_MIN];
      bus.running  <= running_nxt;
    end
  end

  always @(posedge clk_100Hz) begin
    if (rst_n && (HOLD_DLY == 0 || CLR_HOLD == 0 || RPT_PER < 1))
      $error("stopwatch_cmd_ctrl: HOLD_DLY and CLR_HOLD must be nonzero, RPT_PER >= 1");
  end

endmodule

// File: tb/tb_stopwatch_cmd_ctrl.sv
// Randomized and directed bench for stopwatch_cmd_ctrl against a hold-length based reference model.
// Builds with or without STOPWATCH_AUTO_RPT_EN; the model follows the same macro.
module tb_stopwatch_cmd_ctrl;
  localparam int HOLD_DLY = 50;
  localparam int RPT_PER  = 10;
  localparam int CLR_HOLD = 200;
  localparam int CNT_W    = 8;
`ifdef STOPWATCH_AUTO_RPT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk_100Hz = 1'b0;
  logic rst_n     = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  stopwatch_cmd_ctrl_if bus ();

  stopwatch_cmd_ctrl #(.HOLD_DLY(HOLD_DLY), .RPT_PER(RPT_PER), .CLR_HOLD(CLR_HOLD), .CNT_W(CNT_W)) dut (
    .clk_100Hz (clk_100Hz),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  // Reference model: commands indexed by priority, 0 = stop, 1 = clr, 2 = start, 3 = hour, 4 = min.
  bit       m_run;
  bit       m_pend [5];
  int       len_ss, len_inc [2];
  bit       ss_stop_mode, last_stopped;
  int       since_stop;
  bit [5:0] m_out;   // {stop, clr, start, hour_inc, min_inc, running}

  task automatic model_reset();
    m_run = 0; len_ss = 0; len_inc[0] = 0; len_inc[1] = 0;
    ss_stop_mode = 0; last_stopped = 0; since_stop = 1000; m_out = '0;
    for (int j = 0; j < 5; j++) m_pend[j] = 0;
  endtask

  task automatic model_step(input bit ss, input bit mn, input bit hr, input bit stp);
    bit ev [5];
    bit req [5];
    bit b, auto_stop;
    int g, k;
    for (int j = 0; j < 5; j++) ev[j] = 0;
    if (ss) begin
      if (len_ss == 0) begin
        ss_stop_mode = m_run;
        ev[0] = m_run;
      end else if (!ss_stop_mode && len_ss == CLR_HOLD) ev[1] = 1;
    end else if (len_ss > 0 && !ss_stop_mode && len_ss <= CLR_HOLD) ev[2] = 1;
    len_ss = ss ? (len_ss < 100000 ? len_ss + 1 : len_ss) : 0;
    for (int i = 0; i < 2; i++) begin
      b = (i == 0) ? hr : mn;
      k = len_inc[i];
      if (b && !m_run && (k == 0 || (AUTO && k >= HOLD_DLY && (k - HOLD_DLY) % RPT_PER == 0)))
        ev[3 + i] = 1;
      len_inc[i] = b ? (k < 100000 ? k + 1 : k) : 0;
    end
    auto_stop = stp && !last_stopped && m_run && since_stop > 2;
    for (int j = 0; j < 5; j++) req[j] = m_pend[j] | ev[j];
    if (auto_stop) req[0] = 0;
    if (m_run) req[2] = 0;
    g = -1;
    for (int j = 0; j < 5; j++) if (req[j] && g < 0) g = j;
    for (int j = 0; j < 5; j++) m_pend[j] = req[j] && (j != g);
    if (g == 0) m_pend[2] = 0;
    if (g == 1) for (int j = 0; j < 5; j++) m_pend[j] = 0;
    if (g == 2) m_run = 1;
    else if (g == 0 || g == 1 || auto_stop) m_run = 0;
    since_stop   = (g == 0) ? 1 : (since_stop < 1000 ? since_stop + 1 : since_stop);
    last_stopped = stp;
    m_out = {g == 0, g == 1, g == 2, g == 3, g == 4, m_run};
  endtask

  function automatic logic [5:0] obs();
    return {bus.stop, bus.clr_req, bus.start, bus.hour_inc, bus.min_inc, bus.running};
  endfunction

  // Inputs change just after a falling edge; returns at the next falling edge with the model updated.
  task automatic cycle(input bit ss, input bit mn, input bit hr, input bit stp);
    bus.btn_ss = ss; bus.btn_min = mn; bus.btn_hour = hr; bus.stopped = stp;
    @(posedge clk_100Hz);
    model_step(ss, mn, hr, stp);
    @(negedge clk_100Hz);
  endtask

  task automatic test_reset();
    bus.btn_ss = 1'($urandom); bus.btn_min = 1'($urandom);
    bus.btn_hour = 1'($urandom); bus.stopped = 1'($urandom);
    rst_n = 0;
    repeat (3) @(posedge clk_100Hz);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_100Hz);
      vectors++;
      if (obs() !== 6'b0) begin
        miscompares++; $display("FAIL reset_state cyc=%0d got=%b exp=%b", c, obs(), 6'b0);
      end
    end
    bus.btn_ss = 0; bus.btn_min = 0; bus.btn_hour = 0; bus.stopped = 0;
    rst_n = 1;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      cycle(c < 3, 0, 0, 0);
      vectors++;
      if (obs() !== m_out) begin
        miscompares++; $display("FAIL reset_run cyc=%0d got=%b exp=%b", c, obs(), m_out);
      end
    end
    #2 rst_n = 0;
    #1 vectors++;
    if (obs() !== 6'b0) begin
      miscompares++; $display("FAIL async_reset got=%b exp=%b", obs(), 6'b0);
    end
    bus.btn_min = 1;
    @(negedge clk_100Hz);
    rst_n = 1;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      cycle(0, c == 0, 0, 0);
      vectors++;
      if (obs() !== m_out) begin
        miscompares++; $display("FAIL held_thru_reset cyc=%0d got=%b exp=%b", c, obs(), m_out);
      end
    end
  endtask

  task automatic test_start();
    int start_at = -1, n_start = 0, n_clr = 0;
    for (int c = 0; c < 16; c++) begin
      cycle(c < 10, 0, 0, 0);
      vectors++;
      if (obs() !== m_out) begin
        miscompares++; $display("FAIL start_seq cyc=%0d got=%b exp=%b", c, obs(), m_out);
      end
      if (bus.start === 1'b1) begin n_start++; if (start_at < 0) start_at = c; end
      if (bus.clr_req === 1'b1) n_clr++;
    end
    vectors++;
    if (start_at !== 10 || n_start !== 1 || n_clr !== 0 || bus.running !== 1'b1) begin
      miscompares++;
      $display("FAIL start_timing at=%0d n=%0d clr=%0d run=%b, want at=10 n=1 clr=0 run=1",
               start_at, n_start, n_clr, bus.running);
    end
  endtask

  task automatic test_stop();
    int stop_at = -1, n_stop = 0, n_other = 0;
    for (int c = 0; c < 310; c++) begin
      cycle(c < 300, 0, 0, 0);
      vectors++;
      if (obs() !== m_out) begin
        miscompares++; $display("FAIL stop_seq cyc=%0d got=%b exp=%b", c, obs(), m_out);
      end
      if (bus.stop === 1'b1) begin n_stop++; if (stop_at < 0) stop_at = c; end
      if (bus.start === 1'b1 || bus.clr_req === 1'b1) n_other++;
    end
    vectors++;
    if (stop_at !== 0 || n_stop !== 1 || n_other !== 0 || bus.running !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_timing at=%0d n=%0d other=%0d run=%b, want at=0 n=1 other=0 run=0",
               stop_at, n_stop, n_other, bus.running);
    end
  endtask

  task automatic test_clear();
    int clr_at = -1, n_clr = 0, n_start = 0;
    for (int c = 0; c < 260; c++) begin
      cycle(c < 250, 0, 0, 0);
      vectors++;
      if (obs() !== m_out) begin
        miscompares++; $display("FAIL clear_seq cyc=%0d got=%b exp=%b", c, obs(), m_out);
      end
      if (bus.clr_req === 1'b1) begin n_clr++; if (clr_at < 0) clr_at = c; end
      if (bus.start === 1'b1) n_start++;
    end
    vectors++;
    if (clr_at !== CLR_HOLD || n_clr !== 1 || n_start !== 0) begin
      miscompares++;
      $display("FAIL clear_timing at=%0d n=%0d start=%0d, want at=%0d n=1 start=0",
               clr_at, n_clr, n_start, CLR_HOLD);
    end
  endtask

  task automatic test_auto_rpt();
    int got [$];
    int want [$];
    want.push_back(0);
    if (AUTO) for (int t = HOLD_DLY; t < 100; t += RPT_PER) want.push_back(t);
    for (int c = 0; c < 110; c++) begin
      cycle(0, c < 100, 0, 0);
      vectors++;
      if (obs() !== m_out) begin
        miscompares++; $display("FAIL rpt_seq cyc=%0d got=%b exp=%b", c, obs(), m_out);
      end
      if (bus.min_inc === 1'b1) got.push_back(c);
    end
    vectors++;
    if (got.size() != want.size()) begin
      miscompares++; $display("FAIL rpt_count got=%0d want=%0d", got.size(), want.size());
    end else begin
      for (int i = 0; i < want.size(); i++) begin
        vectors++;
        if (got[i] != want[i]) begin
          miscompares++; $display("FAIL rpt_pos idx=%0d got=%0d want=%0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_same_edge();
    int hour_at = -1, min_at = -1, both = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(0, c < 3, c < 3, 0);
      vectors++;
      if (obs() !== m_out) begin
        miscompares++; $display("FAIL same_edge_seq cyc=%0d got=%b exp=%b", c, obs(), m_out);
      end
      if (bus.hour_inc === 1'b1 && hour_at < 0) hour_at = c;
      if (bus.min_inc === 1'b1 && min_at < 0) min_at = c;
      if (bus.hour_inc === 1'b1 && bus.min_inc === 1'b1) both++;
    end
    vectors++;
    if (hour_at !== 0 || min_at !== 1 || both !== 0) begin
      miscompares++;
      $display("FAIL same_edge_order hour=%0d min=%0d both=%0d, want hour=0 min=1 both=0",
               hour_at, min_at, both);
    end
  endtask

  task automatic test_autostop();
    int n_min = 0, min_at = -1;
    logic run19 = 1'bx, run20 = 1'bx;
    for (int c = 0; c < 40; c++) begin
      cycle(c < 3, (c >= 10 && c < 14) || (c >= 25 && c < 28), 0, c >= 20 && c < 35);
      vectors++;
      if (obs() !== m_out) begin
        miscompares++; $display("FAIL autostop_seq cyc=%0d got=%b exp=%b", c, obs(), m_out);
      end
      if (c == 19) run19 = bus.running;
      if (c == 20) run20 = bus.running;
      if (bus.min_inc === 1'b1) begin n_min++; if (min_at < 0) min_at = c; end
    end
    vectors++;
    if (run19 !== 1'b1 || run20 !== 1'b0 || n_min !== 1 || min_at !== 25) begin
      miscompares++;
      $display("FAIL autostop_result run19=%b run20=%b n_min=%0d at=%0d, want 1 0 1 25",
               run19, run20, n_min, min_at);
    end
  endtask

  task automatic test_random();
    bit ss = 0, mn = 0, hr = 0, stp = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, (c < 2000) ? 29 : 149) == 0) ss = ~ss;
      if ($urandom_range(0, 24) == 0) mn = ~mn;
      if ($urandom_range(0, 24) == 0) hr = ~hr;
      if ($urandom_range(0, 39) == 0) stp = ~stp;
      cycle(ss, mn, hr, stp);
      vectors++;
      if (obs() !== m_out) begin
        miscompares++; $display("FAIL random cyc=%0d got=%b exp=%b", c, obs(), m_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_stop();
    test_clear();
    test_auto_rpt();
    test_same_edge();
    test_autostop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
